// File: rtl/float_pkg.sv
// Shared float ordering rules for the comparison, max-select and argmax units.
// Values are passed zero-extended to MAX_W bits along with their real widths,
// so one set of functions serves every DATA_W/EXP_W combination.
package float_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] fword_t;

  function automatic fword_t field_mask(input int n);
    if (n >= MAX_W) return '1;
    return (fword_t'(1) << n) - fword_t'(1);
  endfunction

  function automatic logic is_nan(input fword_t v, input int dw, input int ew);
    int     mw;
    fword_t e;
    fword_t m;
    mw = dw - 1 - ew;
    e  = (v >> mw) & field_mask(ew);
    m  = v & field_mask(mw);
    return (e == field_mask(ew)) && (m != '0);
  endfunction

  // a > b under sign-magnitude ordering; any NaN operand makes it false.
  // +0 > -0 falls out of the differing-sign rule.
  function automatic logic float_greater(input fword_t a, input fword_t b,
                                         input int dw, input int ew);
    logic   sign_a;
    logic   sign_b;
    fword_t mag_a;
    fword_t mag_b;
    if (is_nan(a, dw, ew) || is_nan(b, dw, ew)) return 1'b0;
    sign_a = a[dw-1];
    sign_b = b[dw-1];
    mag_a  = a & field_mask(dw - 1);
    mag_b  = b & field_mask(dw - 1);
    if (sign_a != sign_b) return !sign_a;
    if (!sign_a) return mag_a > mag_b;
    return mag_a < mag_b;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic fword_t canon_nan(input int dw, input int ew);
    int mw;
    mw = dw - 1 - ew;
    return (field_mask(ew) << mw) | (fword_t'(1) << (mw - 1));
  endfunction

endpackage

// File: rtl/float_max_select.sv
// Combinational keep-or-replace decision for a running extreme value.
// invert=0 selects a strictly greater candidate (max); invert=1 a strictly
// smaller one (min). NaN candidates never win; an empty slot takes any non-NaN.
module float_max_select
  import float_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-1:0] cand,
  input  logic [DATA_W-1:0] cur,
  input  logic              cur_valid,
  input  logic              invert,
  output logic              update
);

  logic cand_nan;
  logic beats;

  // Ordering decision between candidate and current holder
  always_comb begin
    cand_nan = is_nan(fword_t'(cand), DATA_W, EXP_W);
    beats    = invert ? float_greater(fword_t'(cur), fword_t'(cand), DATA_W, EXP_W)
                      : float_greater(fword_t'(cand), fword_t'(cur), DATA_W, EXP_W);
    update   = !cand_nan && (!cur_valid || beats);
  end

endmodule

// File: rtl/float_argmax_reduce.sv
// Streaming float max/argmax reducer. A run pulse (re)starts a reduction of
// `length` elements; out0/out1 track the max and the index of its first
// occurrence, and done rises with the final element's update.
//
// state | meaning
// IDLE  | waiting for run
// ACC   | accepting elements while in0_valid & running
// FIN   | result held, done=1, further elements ignored
module float_argmax_reduce
  import float_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] in0,
  input  logic              in0_valid,
  input  logic              start,
  output logic              done,
  output logic [DATA_W-1:0] out0,
  output logic [LEN_W-1:0]  out1
);

  localparam logic [DATA_W-1:0] CANON_NAN = DATA_W'(canon_nan(DATA_W, EXP_W));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  count_inc;
  logic              max_valid;
  logic              accept;
  logic              last;
  logic              update;
  logic              start_d;
  logic              unused_start;

  assign count_inc    = count + 1'b1;
  assign accept       = (state == ACC) && in0_valid && running && !run;
  assign last         = (count_inc == len_q);
  assign unused_start = start_d;

  float_max_select #(
    .DATA_W (DATA_W),
    .EXP_W  (EXP_W)
  ) u_select (
    .cand      (in0),
    .cur       (out0),
    .cur_valid (max_valid),
    .invert    (1'b0),
    .update    (update)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; run restarts from any state
  always_comb begin
    state_next = state;
    if (run) begin
      state_next = (length == '0) ? FIN : ACC;
    end else begin
      case (state)
        ACC:     if (accept && last) state_next = FIN;
        default: state_next = state;
      endcase
    end
  end

  // Datapath: counters, running max/index and done level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      count     <= '0;
      max_valid <= 1'b0;
      len_q     <= '0;
      start_d   <= 1'b0;
    end else begin
      start_d <= start;
      done    <= (state_next == FIN);
      if (run) begin
        len_q     <= length;
        count     <= '0;
        max_valid <= 1'b0;
        // A zero-length run enters FIN on this edge with no valid max
        if (length == '0) begin
          out0 <= CANON_NAN;
          out1 <= '1;
        end else begin
          out0 <= '0;
          out1 <= '0;
        end
      end else if (accept) begin
        count <= count_inc;
        if (update) begin
          out0      <= in0;
          out1      <= count;
          max_valid <= 1'b1;
        end else if (last && !max_valid) begin
          out0 <= CANON_NAN;
          out1 <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_argmax_reduce.sv
// Directed bench for float_argmax_reduce: expected results are queued when a
// job is started and popped when done rises.
module tb_float_argmax_reduce;

  typedef struct {
    logic [31:0] val;
    logic [15:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        running = 1'b1;
  logic        run = 1'b0;
  logic [15:0] length = '0;
  logic [31:0] in0 = '0;
  logic        in0_valid = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [31:0] out0;
  logic [15:0] out1;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  float_argmax_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .running   (running),
    .run       (run),
    .length    (length),
    .in0       (in0),
    .in0_valid (in0_valid),
    .start     (start),
    .done      (done),
    .out0      (out0),
    .out1      (out1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pulse_run(input logic [15:0] len, input logic [31:0] ev, input logic [15:0] ei);
    exp_t e;
    @(negedge clk);
    run = 1'b1;
    length = len;
    in0_valid = 1'b1;
    in0 = 32'h7F800000;
    e.val = ev;
    e.idx = ei;
    sb.push_back(e);
    @(negedge clk);
    run = 1'b0;
    in0_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    in0 = v;
    in0_valid = 1'b1;
    @(negedge clk);
    in0_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_out0"}, out0, e.val);
      check({tag, "_out1"}, {16'd0, out1}, {16'd0, e.idx});
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out0", out0, 32'd0);
    check("rst_out1", {16'd0, out1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: tie keeps the first index; FIN ignores later elements
    pulse_run(16'd4, 32'h40600000, 16'd1);
    send(32'h3F800000);
    check("t1_lat_out0", out0, 32'h3F800000);
    send(32'h40600000);
    check("t1_mid_out1", {16'd0, out1}, 32'd1);
    send(32'hC0000000);
    check("t1_pre_done", {31'd0, done}, 32'd0);
    send(32'h40600000);
    check("t1_done_edge", {31'd0, done}, 32'd1);
    wait_done("t1");
    send(32'h7F800000);
    check("t1_hold_out0", out0, 32'h40600000);
    check("t1_hold_done", {31'd0, done}, 32'd1);

    // 2: NaN consumed but never selected; negatives order by smaller magnitude
    pulse_run(16'd3, 32'hBF800000, 16'd2);
    check("t2_run_clr", {31'd0, done}, 32'd0);
    send(32'h7FC00001);
    send(32'hC0A00000);
    send(32'hBF800000);
    wait_done("t2");

    // 3: all-NaN stream gives canonical NaN and all-ones index
    pulse_run(16'd2, 32'h7FC00000, 16'hFFFF);
    send(32'h7FC00000);
    send(32'hFFC00000);
    wait_done("t3");

    // 4: signed zeros and +Inf with stall cycles between elements
    pulse_run(16'd3, 32'h7F800000, 16'd2);
    send(32'h00000000);
    idle(2);
    send(32'h80000000);
    check("t4_negzero_out0", out0, 32'h00000000);
    check("t4_negzero_out1", {16'd0, out1}, 32'd0);
    idle(2);
    check("t4_stall_done", {31'd0, done}, 32'd0);
    send(32'h7F800000);
    wait_done("t4");

    // 5: zero-length job, then a restart mid-run plus a running=0 stall
    pulse_run(16'd0, 32'h7FC00000, 16'hFFFF);
    check("t5_len0_done", {31'd0, done}, 32'd1);
    wait_done("t5a");
    pulse_run(16'd5, 32'h3F800000, 16'd0);
    send(32'h40A00000);
    send(32'h40C00000);
    check("t5_partial", out0, 32'h40C00000);
    void'(sb.pop_front());
    pulse_run(16'd2, 32'h3F800000, 16'd0);
    check("t5_restart_out0", out0, 32'd0);
    check("t5_restart_done", {31'd0, done}, 32'd0);
    running = 1'b0;
    send(32'h41100000);
    running = 1'b1;
    check("t5_gated_out0", out0, 32'd0);
    send(32'h3F800000);
    check("t5_pre_done", {31'd0, done}, 32'd0);
    send(32'hC0400000);
    wait_done("t5b");

    // 6: async reset mid-reduction, then elements without run are ignored
    pulse_run(16'd4, 32'd0, 16'd0);
    void'(sb.pop_front());
    send(32'h40000000);
    send(32'h40800000);
    check("t6_before_rst", out0, 32'h40800000);
    #2 rst = 1'b1;
    #1;
    check("t6_async_out0", out0, 32'd0);
    check("t6_async_out1", {16'd0, out1}, 32'd0);
    check("t6_async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(32'h40800000);
    send(32'h40800000);
    send(32'h40800000);
    send(32'h40800000);
    check("t6_norun_out0", out0, 32'd0);
    check("t6_norun_done", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_argmax_reduce.md
Name: float_argmax_reduce

Overview:
- Streaming floating-point max/argmax reducer in the Versat unit library.
- Consumes a stream of DATA_W-bit IEEE-754-style values, one per accepted cycle, over a configured run length.
- Produces the running maximum and the index of its first occurrence.
- Sits downstream of the float comparison unit and uses the same ordering and NaN rules, so a max-select datapath gives identical results to compare-then-mux chains built from that unit.

Parameters:
DATA_W, 32, total float width (sign + exponent + mantissa)
EXP_W, 8, exponent field width
LEN_W, 16, width of length config and index output

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
running  input  1  accelerator running; element acceptance gated by it
run  input  1  single-cycle pulse; (re)starts a reduction
length  input  LEN_W  number of elements to reduce; sampled on run
in0  input  DATA_W  candidate value
in0_valid  input  1  in0 carries an element this cycle
start  input  1  unit start strobe; registered into start_d (internal)
done  output  1  reduction complete; level
out0  output  DATA_W  current/final max value
out1  output  LEN_W  index of out0 within the stream

Behaviour:
- Reset (async):
  - state=IDLE, done=0, out0=0, out1=0.
  - count=0, max_valid=0, len_q=0.
- States:
  - IDLE: waits for run.
  - ACC: accepts elements.
  - FIN: done held.
- run (any state, highest priority):
  - len_q<=length, count<=0, max_valid<=0, done<=0, out0<=0, out1<=0.
  - Next state is ACC, or FIN when length==0.
  - An element presented in the run cycle is ignored.
- length==0 path: FIN is entered one cycle after run, with done=1, out0=canonical NaN, out1=all ones.
- Canonical NaN: sign 0, exponent all ones, mantissa MSB 1, remaining bits 0 (0x7FC00000 at DATA_W=32).
- Accepting an element in ACC:
  - Acceptance condition: in0_valid & running. Otherwise no state change (stall).
  - NaN: exponent field all ones and mantissa nonzero.
  - Greater test, cand>max:
    - both signs 1: cand magnitude < max magnitude
    - signs equal and 0: cand magnitude > max magnitude
    - signs differ: cand sign==0
    - result is false if either operand is NaN.
  - Update rule: if cand is not NaN and (!max_valid or cand>max), then out0<=in0, out1<=count, max_valid<=1.
  - Strict greater: ties keep the earliest index.
  - +0 beats -0 (sign rule); -0 arriving after +0 does not replace it.
  - NaN elements are consumed (count increments) but never selected.
  - count<=count+1 on every accepted element.
  - When count+1==len_q on an accepted element, next state is FIN and done<=1 in the same edge.
- Latency:
  - out0/out1 reflect an accepted element one cycle after acceptance.
  - done rises on the same edge as the final element's update.
- FIN:
  - If max_valid==0 (all elements NaN): out0<=canonical NaN, out1<=all ones, applied on the FIN entry edge.
  - done stays 1, outputs hold, and further in0_valid is ignored until the next run or rst.
- Infinities compare by bit magnitude: +Inf wins over all finite values; -Inf loses to all.
- No overflow handling on count: len_q bounds it, and the max length is 2^LEN_W-1.
- rst mid-reduction returns to the reset values immediately; the partial result is lost.
- start is not used for control; done is driven only by the FSM.

Decomposition:
- Shared package float_pkg:
  - is_nan and float_greater functions, parameterized by DATA_W/EXP_W.
  - CANON_NAN constant builder.
  - The comparison unit adopts the same functions for rule parity.
- State encoding localparams (IDLE/ACC/FIN) stay local.
- One natural sub-module: float_max_select, a combinational greater+NaN+valid decision returning an update flag, reusable by a future min reducer via an invert input.

Test Plan:
1. length=4, stream 1.0(0x3F800000), 3.5(0x40600000), -2.0(0xC0000000), 3.5 -> done after 4th accept; out0=0x40600000, out1=1 (tie keeps first).
2. length=3, stream NaN(0x7FC00001), -5.0(0xC0A00000), -1.0(0xBF800000) -> out0=0xBF800000, out1=2; NaN counted, not selected.
3. length=2, stream 0x7FC00000, 0xFFC00000 -> done=1; out0=0x7FC00000, out1=0xFFFF.
4. length=3, stream +0, -0, +Inf with in0_valid low for 2 cycles between elements -> stalls honored; out0=0x7F800000, out1=2; done only after 3rd valid.
5. length=0 run pulse -> next cycle done=1, out0=0x7FC00000, out1=0xFFFF; mid-run of a length=5 job, pulse run with length=2 -> counters restart, result reflects only the 2 new elements.
6. Assert rst after 2 of 4 elements -> out0=0, out1=0, done=0 asynchronously; post-reset elements without run are ignored.
